// File: rtl/umi_address_remap_cfg.sv
// Config register target holding shadow/active remap and offset tables for umi_address_remap.
// Latency: response valid 1 cycle after request accept; one request outstanding at a time.
// Backpressure: udev_req_ready drops while a response is held; the response is held until udev_resp_ready.
//
// Ports: clk/nreset (async active-low); udev_req_* config request in; udev_resp_* response out;
// dp_idle from the remap datapath gates commit; remap_enable, old/new_row_col_address and
// set_dstaddress_low/high/offset are the active table driven into the remap.
// Optional macro UMI_REMAP_CFG_LOCK_EN adds a sticky CTRL.LOCK bit that freezes all tables.
module umi_address_remap_cfg #(
    parameter int CW    = 32,
    parameter int AW    = 64,
    parameter int DW    = 128,
    parameter int IDW   = 16,
    parameter int NMAPS = 8,
    parameter int RAW   = 8
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 udev_req_valid,
    input  logic [CW-1:0]        udev_req_cmd,
    input  logic [AW-1:0]        udev_req_dstaddr,
    input  logic [AW-1:0]        udev_req_srcaddr,
    input  logic [DW-1:0]        udev_req_data,
    output logic                 udev_req_ready,
    output logic                 udev_resp_valid,
    output logic [CW-1:0]        udev_resp_cmd,
    output logic [AW-1:0]        udev_resp_dstaddr,
    output logic [AW-1:0]        udev_resp_srcaddr,
    output logic [DW-1:0]        udev_resp_data,
    input  logic                 udev_resp_ready,
    input  logic                 dp_idle,
    output logic                 remap_enable,
    output logic [IDW*NMAPS-1:0] old_row_col_address,
    output logic [IDW*NMAPS-1:0] new_row_col_address,
    output logic [AW-1:0]        set_dstaddress_low,
    output logic [AW-1:0]        set_dstaddress_high,
    output logic [AW-1:0]        set_dstaddress_offset
);

    localparam logic [4:0] REQ_READ   = 5'h01;
    localparam logic [4:0] REQ_WRITE  = 5'h03;
    localparam logic [4:0] REQ_POSTED = 5'h05;
    localparam logic [4:0] RESP_READ  = 5'h02;
    localparam logic [4:0] RESP_WRITE = 5'h04;

    localparam logic [RAW-1:0] A_CTRL   = 'h00;
    localparam logic [RAW-1:0] A_STATUS = 'h04;
    localparam logic [RAW-1:0] A_LOW_L  = 'h08;
    localparam logic [RAW-1:0] A_LOW_H  = 'h0C;
    localparam logic [RAW-1:0] A_HIGH_L = 'h10;
    localparam logic [RAW-1:0] A_HIGH_H = 'h14;
    localparam logic [RAW-1:0] A_OFF_L  = 'h18;
    localparam logic [RAW-1:0] A_OFF_H  = 'h1C;
    localparam logic [RAW-1:0] A_TBL    = 'h20;
    localparam int IW = (NMAPS > 1) ? $clog2(NMAPS) : 1;

    typedef enum logic {S_IDLE, S_RESP} state_t;
    state_t state_q, state_d;

    // shadow (software-visible) and active (driven to the remap) sets
    logic                      sh_en, act_en;
    logic [AW-1:0]             sh_low, sh_high, sh_off;
    logic [AW-1:0]             act_low, act_high, act_off;
    logic [NMAPS-1:0][IDW-1:0] sh_old, sh_new, act_old, act_new;
    logic                      pending;
    logic                      locked;

    logic [CW-1:0] resp_cmd;
    logic [AW-1:0] resp_dst, resp_src;
    logic [DW-1:0] resp_data;

    // request decode
    logic [4:0]     opc;
    logic           is_rd, is_pw, is_write, shape_ok, hit, ro, ok;
    logic [RAW-1:0] off, tbl_ent;
    logic [IW-1:0]  tbl_idx;
    logic [31:0]    rdata;
    logic           accept, wr_en, apply, commit;

    assign opc      = udev_req_cmd[4:0];
    assign is_rd    = (opc == REQ_READ);
    assign is_pw    = (opc == REQ_POSTED);
    assign is_write = (opc == REQ_WRITE) || is_pw;
    assign shape_ok = (udev_req_cmd[7:5] == 3'd2) && (udev_req_cmd[15:8] == 8'd0);
    assign off      = udev_req_dstaddr[RAW-1:0];
    // OLD[i]/NEW[i] pairs are 8 bytes apart; bit 2 picks NEW within the pair
    assign tbl_ent  = (off - A_TBL) >> 3;
    assign tbl_idx  = tbl_ent[IW-1:0];

    always_comb begin
        hit   = 1'b0;
        ro    = 1'b0;
        rdata = 32'd0;
        if (off[1:0] == 2'b00) begin
            if (off >= A_TBL) begin
                if (tbl_ent < RAW'(NMAPS)) begin
                    hit   = 1'b1;
                    rdata = off[2] ? 32'(sh_new[tbl_idx]) : 32'(sh_old[tbl_idx]);
                end
            end else begin
                hit = 1'b1;
                case (off)
                    A_CTRL:   rdata = {29'd0, locked, sh_en, 1'b0};
                    A_STATUS: begin
                        ro    = 1'b1;
                        rdata = {29'd0, locked, act_en, pending};
                    end
                    A_LOW_L:  rdata = sh_low[31:0];
                    A_LOW_H:  rdata = 32'(sh_low[AW-1:32]);
                    A_HIGH_L: rdata = sh_high[31:0];
                    A_HIGH_H: rdata = 32'(sh_high[AW-1:32]);
                    A_OFF_L:  rdata = sh_off[31:0];
                    A_OFF_H:  rdata = 32'(sh_off[AW-1:32]);
                    default:  hit = 1'b0;
                endcase
            end
        end
    end

    assign ok     = (is_rd || is_write) && shape_ok && hit && !(is_write && (ro || locked));
    assign accept = udev_req_valid && (state_q == S_IDLE);
    assign wr_en  = accept && ok && is_write;
    assign commit = wr_en && (off == A_CTRL) && udev_req_data[0];
    // a locked block never applies, so the active set stays frozen too
    assign apply  = pending && dp_idle && !locked;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept && !is_pw) state_d = S_RESP;
            S_RESP: if (udev_resp_ready)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= S_IDLE;
            resp_cmd  <= '0;
            resp_dst  <= '0;
            resp_src  <= '0;
            resp_data <= '0;
        end else begin
            state_q <= state_d;
            if (accept && !is_pw) begin
                resp_cmd  <= {{(CW-27){1'b0}}, (ok ? 2'b00 : 2'b11), udev_req_cmd[24:5],
                              (is_rd ? RESP_READ : RESP_WRITE)};
                resp_dst  <= udev_req_srcaddr;
                resp_src  <= udev_req_dstaddr;
                resp_data <= (ok && is_rd) ? DW'(rdata) : '0;
            end
        end
    end

    // shadow writes, commit and apply; apply copies the pre-write shadow values
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sh_en    <= 1'b0;
            sh_low   <= '0;
            sh_high  <= '0;
            sh_off   <= '0;
            sh_old   <= '0;
            sh_new   <= '0;
            act_en   <= 1'b0;
            act_low  <= '0;
            act_high <= '0;
            act_off  <= '0;
            act_old  <= '0;
            act_new  <= '0;
            pending  <= 1'b0;
        end else begin
            if (apply) begin
                act_en   <= sh_en;
                act_low  <= sh_low;
                act_high <= sh_high;
                act_off  <= sh_off;
                act_old  <= sh_old;
                act_new  <= sh_new;
            end
            // a commit landing on the apply cycle re-arms for the next apply
            pending <= commit || (pending && !apply);
            if (wr_en) begin
                if (off >= A_TBL) begin
                    if (off[2]) sh_new[tbl_idx] <= udev_req_data[IDW-1:0];
                    else        sh_old[tbl_idx] <= udev_req_data[IDW-1:0];
                end else begin
                    case (off)
                        A_CTRL:   sh_en              <= udev_req_data[1];
                        A_LOW_L:  sh_low[31:0]       <= udev_req_data[31:0];
                        A_LOW_H:  sh_low[AW-1:32]    <= udev_req_data[AW-33:0];
                        A_HIGH_L: sh_high[31:0]      <= udev_req_data[31:0];
                        A_HIGH_H: sh_high[AW-1:32]   <= udev_req_data[AW-33:0];
                        A_OFF_L:  sh_off[31:0]       <= udev_req_data[31:0];
                        A_OFF_H:  sh_off[AW-1:32]    <= udev_req_data[AW-33:0];
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef UMI_REMAP_CFG_LOCK_EN
    logic lock_q;
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)                                          lock_q <= 1'b0;
        else if (wr_en && (off == A_CTRL) && udev_req_data[2]) lock_q <= 1'b1;
    end
    assign locked = lock_q;
`else
    assign locked = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{udev_req_data[DW-1:32], udev_req_cmd[CW-1:25], udev_req_dstaddr[AW-1:RAW]};

    assign udev_req_ready    = (state_q == S_IDLE);
    assign udev_resp_valid   = (state_q == S_RESP);
    assign udev_resp_cmd     = resp_cmd;
    assign udev_resp_dstaddr = resp_dst;
    assign udev_resp_srcaddr = resp_src;
    assign udev_resp_data    = resp_data;

    // disabled remap: identity ID mapping and an empty offset window
    assign remap_enable          = act_en;
    assign old_row_col_address   = act_old;
    assign new_row_col_address   = act_en ? act_new : act_old;
    assign set_dstaddress_low    = act_en ? act_low : {AW{1'b1}};
    assign set_dstaddress_high   = act_en ? act_high : '0;
    assign set_dstaddress_offset = act_off;

endmodule

// File: tb/tb_umi_address_remap_cfg.sv
module tb_umi_address_remap_cfg;
    localparam int CW = 32, AW = 64, DW = 128, IDW = 16, NMAPS = 8, RAW = 8;

    logic clk, nreset;
    logic udev_req_valid, udev_req_ready, udev_resp_valid, udev_resp_ready, dp_idle;
    logic [CW-1:0] udev_req_cmd, udev_resp_cmd;
    logic [AW-1:0] udev_req_dstaddr, udev_req_srcaddr, udev_resp_dstaddr, udev_resp_srcaddr;
    logic [DW-1:0] udev_req_data, udev_resp_data;
    logic remap_enable;
    logic [IDW*NMAPS-1:0] old_row_col_address, new_row_col_address;
    logic [AW-1:0] set_dstaddress_low, set_dstaddress_high, set_dstaddress_offset;

    umi_address_remap_cfg #(.CW(CW), .AW(AW), .DW(DW), .IDW(IDW), .NMAPS(NMAPS), .RAW(RAW)) dut (
        .clk(clk), .nreset(nreset),
        .udev_req_valid(udev_req_valid), .udev_req_cmd(udev_req_cmd),
        .udev_req_dstaddr(udev_req_dstaddr), .udev_req_srcaddr(udev_req_srcaddr),
        .udev_req_data(udev_req_data), .udev_req_ready(udev_req_ready),
        .udev_resp_valid(udev_resp_valid), .udev_resp_cmd(udev_resp_cmd),
        .udev_resp_dstaddr(udev_resp_dstaddr), .udev_resp_srcaddr(udev_resp_srcaddr),
        .udev_resp_data(udev_resp_data), .udev_resp_ready(udev_resp_ready),
        .dp_idle(dp_idle), .remap_enable(remap_enable),
        .old_row_col_address(old_row_col_address), .new_row_col_address(new_row_col_address),
        .set_dstaddress_low(set_dstaddress_low), .set_dstaddress_high(set_dstaddress_high),
        .set_dstaddress_offset(set_dstaddress_offset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: byte-offset-indexed register images of shadow and active sets
    logic [31:0] sh  [256];
    logic [31:0] act [256];
    bit m_pending, m_busy;
    logic [CW-1:0] e_cmd;
    logic [AW-1:0] e_dst, e_src;
    logic [DW-1:0] e_data;

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 256; k++) begin
            sh[k] = '0;
            act[k] = '0;
        end
        m_pending = 0;
        m_busy = 0;
    endtask

    function automatic bit mapped(int off);
        return (off % 4 == 0) && ((off < 32) || ((off - 32) / 8 < NMAPS));
    endfunction

    function automatic logic [31:0] wmask(int off);
`ifdef UMI_REMAP_CFG_LOCK_EN
        if (off == 0) return 32'h6;
`else
        if (off == 0) return 32'h2;
`endif
        if (off >= 32) return (32'd1 << IDW) - 32'd1;
        return 32'hFFFF_FFFF;
    endfunction

    // one clock edge of the model: respond from pre-edge state, apply, then write shadow
    task automatic model_edge(input bit acc);
        logic [4:0] opc;
        bit rd, wr, ok;
        int off;
        logic [31:0] rv, wd;
        opc = udev_req_cmd[4:0];
        rd  = (opc == 5'h01);
        wr  = (opc == 5'h03) || (opc == 5'h05);
        off = int'(udev_req_dstaddr[7:0]);
        wd  = udev_req_data[31:0];
        ok  = (rd || wr) && (udev_req_cmd[7:5] == 3'd2) && (udev_req_cmd[15:8] == 8'd0) &&
              mapped(off) && !(wr && (off == 4 || sh[0][2]));
        rv = '0;
        if (off == 4) rv = {29'd0, sh[0][2], act[0][1], m_pending};
        else if (ok)  rv = sh[off];
        if (acc) begin
            e_cmd  = {5'd0, (ok ? 2'b00 : 2'b11), udev_req_cmd[24:5], (rd ? 5'h02 : 5'h04)};
            e_dst  = udev_req_srcaddr;
            e_src  = udev_req_dstaddr;
            e_data = (ok && rd) ? DW'(rv) : '0;
        end
        if (m_pending && dp_idle && !sh[0][2]) begin
            for (int k = 0; k < 256; k++) act[k] = sh[k];
            m_pending = 0;
        end
        if (acc && ok && wr) begin
            sh[off] = wd & wmask(off);
            if (off == 0 && wd[0]) m_pending = 1;
        end
    endtask

    // negedge to negedge; inputs are stable across the posedge the model evaluates
    task automatic tick();
        bit acc, nb;
        acc = udev_req_valid && !m_busy;
        nb  = m_busy;
        if (m_busy && udev_resp_ready) nb = 0;
        if (acc && udev_req_cmd[4:0] != 5'h05) nb = 1;
        @(posedge clk);
        model_edge(acc);
        m_busy = nb;
        @(negedge clk);
    endtask

    task automatic check_outputs();
        logic [IDW*NMAPS-1:0] eo, en;
        logic ee;
        ee = act[0][1];
        for (int i = 0; i < NMAPS; i++) begin
            eo[i*IDW +: IDW] = act[32+8*i][IDW-1:0];
            en[i*IDW +: IDW] = ee ? act[36+8*i][IDW-1:0] : act[32+8*i][IDW-1:0];
        end
        chk("remap_enable", remap_enable, ee);
        chk("old_row_col", old_row_col_address, eo);
        chk("new_row_col", new_row_col_address, en);
        chk("win_low", set_dstaddress_low, ee ? {act[12], act[8]} : {AW{1'b1}});
        chk("win_high", set_dstaddress_high, ee ? {act[20], act[16]} : {AW{1'b0}});
        chk("win_offset", set_dstaddress_offset, {act[28], act[24]});
    endtask

    task automatic drive(input logic [4:0] opc, input logic [2:0] sz, input logic [7:0] ln,
                         input logic [AW-1:0] addr, input logic [31:0] wd);
        udev_req_cmd     = {7'd0, 9'($urandom), ln, sz, opc};
        udev_req_dstaddr = addr;
        udev_req_srcaddr = {$urandom, $urandom};
        udev_req_data    = {$urandom, $urandom, $urandom, wd};
        udev_req_valid   = 1'b1;
    endtask

    task automatic req(input logic [4:0] opc, input logic [2:0] sz, input logic [7:0] ln,
                       input logic [AW-1:0] addr, input logic [31:0] wd,
                       output logic [1:0] err, output logic [31:0] rdv);
        int w;
        err = '0;
        rdv = '0;
        drive(opc, sz, ln, addr, wd);
        chk("req_ready_idle", udev_req_ready, 1'b1);
        tick();
        udev_req_valid = 1'b0;
        if (opc != 5'h05) begin
            w = 0;
            while (!udev_resp_valid && w < 20) begin
                tick();
                w++;
            end
            chk("resp_latency", w, 0);
            chk("resp_cmd", udev_resp_cmd, e_cmd);
            chk("resp_dstaddr", udev_resp_dstaddr, e_dst);
            chk("resp_srcaddr", udev_resp_srcaddr, e_src);
            chk("resp_data", udev_resp_data, e_data);
            err = udev_resp_cmd[26:25];
            rdv = udev_resp_data[31:0];
            udev_resp_ready = 1'b1;
            tick();
            udev_resp_ready = 1'b0;
        end
        check_outputs();
    endtask

    typedef struct {
        logic [4:0]  opc;
        logic [2:0]  sz;
        logic [7:0]  ln;
        logic [7:0]  off;
        logic [31:0] wd;
        logic [1:0]  err;
        logic [31:0] rdv;
    } vec_t;

    vec_t vt [18];

    initial begin
        logic [1:0]  err;
        logic [31:0] rdv;
        int k, off;
        logic [4:0] opc;
        logic [2:0] sz;
        logic [7:0] ln;
        logic [31:0] wd;

        vt[0]  = '{5'h01, 3'd2, 8'd0, 8'h04, 32'h0,        2'b00, 32'h0};
        vt[1]  = '{5'h03, 3'd2, 8'd0, 8'h20, 32'h0102,     2'b00, 32'h0};
        vt[2]  = '{5'h03, 3'd2, 8'd0, 8'h24, 32'h0304,     2'b00, 32'h0};
        vt[3]  = '{5'h01, 3'd2, 8'd0, 8'h20, 32'h0,        2'b00, 32'h0102};
        vt[4]  = '{5'h01, 3'd2, 8'd0, 8'h24, 32'h0,        2'b00, 32'h0304};
        vt[5]  = '{5'h01, 3'd3, 8'd0, 8'h20, 32'h0,        2'b11, 32'h0};
        vt[6]  = '{5'h01, 3'd2, 8'd0, 8'h60, 32'h0,        2'b11, 32'h0};
        vt[7]  = '{5'h03, 3'd2, 8'd0, 8'h04, 32'h1,        2'b11, 32'h0};
        vt[8]  = '{5'h01, 3'd2, 8'd0, 8'h22, 32'h0,        2'b11, 32'h0};
        vt[9]  = '{5'h03, 3'd2, 8'd0, 8'h28, 32'hABCD1234, 2'b00, 32'h0};
        vt[10] = '{5'h01, 3'd2, 8'd0, 8'h28, 32'h0,        2'b00, 32'h1234};
        vt[11] = '{5'h07, 3'd2, 8'd0, 8'h20, 32'h0,        2'b11, 32'h0};
        vt[12] = '{5'h01, 3'd2, 8'd1, 8'h20, 32'h0,        2'b11, 32'h0};
        vt[13] = '{5'h05, 3'd2, 8'd0, 8'h08, 32'h1000,     2'b00, 32'h0};
        vt[14] = '{5'h01, 3'd2, 8'd0, 8'h08, 32'h0,        2'b00, 32'h1000};
        vt[15] = '{5'h05, 3'd1, 8'd0, 8'h08, 32'h5555,     2'b00, 32'h0};
        vt[16] = '{5'h01, 3'd2, 8'd0, 8'h08, 32'h0,        2'b00, 32'h1000};
        vt[17] = '{5'h01, 3'd2, 8'd0, 8'h00, 32'h0,        2'b00, 32'h0};

        nreset = 1'b0;
        udev_req_valid = 1'b0;
        udev_req_cmd = '0;
        udev_req_dstaddr = '0;
        udev_req_srcaddr = '0;
        udev_req_data = '0;
        udev_resp_ready = 1'b0;
        dp_idle = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_resp_valid", udev_resp_valid, 1'b0);
        chk("rst_remap_enable", remap_enable, 1'b0);
        chk("rst_old", old_row_col_address, '0);
        chk("rst_new", new_row_col_address, '0);
        chk("rst_high", set_dstaddress_high, '0);
        chk("rst_low_empty", set_dstaddress_low, {AW{1'b1}});
        chk("rst_offset", set_dstaddress_offset, '0);
        nreset = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", udev_req_ready, 1'b1);

        // directed table
        for (int i = 0; i < 18; i++) begin
            req(vt[i].opc, vt[i].sz, vt[i].ln, {56'(i), vt[i].off}, vt[i].wd, err, rdv);
            if (vt[i].opc != 5'h05) begin
                chk($sformatf("vec%0d_err", i), err, vt[i].err);
                chk($sformatf("vec%0d_data", i), rdv, vt[i].rdv);
            end
        end

        // commit held off by a busy datapath
        dp_idle = 1'b0;
        req(5'h03, 3'd2, 8'd0, 64'h00, 32'h3, err, rdv);
        repeat (10) tick();
        chk("hold_old", old_row_col_address[15:0], 16'h0);
        chk("hold_enable", remap_enable, 1'b0);
        req(5'h01, 3'd2, 8'd0, 64'h04, 32'h0, err, rdv);
        chk("hold_pending", rdv, 32'h1);
        dp_idle = 1'b1;
        tick();
        chk("apply_old", old_row_col_address[15:0], 16'h0102);
        chk("apply_new", new_row_col_address[15:0], 16'h0304);
        chk("apply_enable", remap_enable, 1'b1);
        req(5'h01, 3'd2, 8'd0, 64'h04, 32'h0, err, rdv);
        chk("apply_status", rdv, 32'h2);

        // response held under backpressure
        drive(5'h01, 3'd3, 8'd0, 64'h20, 32'h0);
        tick();
        udev_req_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("stall_resp_valid", udev_resp_valid, 1'b1);
            chk("stall_req_ready", udev_req_ready, 1'b0);
            chk("stall_resp_cmd", udev_resp_cmd, e_cmd);
            chk("stall_err", udev_resp_cmd[26:25], 2'b11);
            tick();
        end
        udev_resp_ready = 1'b1;
        tick();
        udev_resp_ready = 1'b0;
        chk("stall_release", udev_req_ready, 1'b1);

        // commit with SH_ENABLE=0 gives identity map and empty window
        req(5'h05, 3'd2, 8'd0, 64'h10, 32'h2000, err, rdv);
        req(5'h03, 3'd2, 8'd0, 64'h00, 32'h1, err, rdv);
        tick();
        check_outputs();
        chk("dis_new_is_old", new_row_col_address[15:0], 16'h0102);
        chk("dis_low", set_dstaddress_low, {AW{1'b1}});
        chk("dis_high", set_dstaddress_high, '0);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 99);
            opc = (k < 40) ? 5'h01 : (k < 75) ? 5'h03 : (k < 95) ? 5'h05 : 5'($urandom);
            sz = ($urandom_range(0, 9) != 0) ? 3'd2 : 3'($urandom);
            ln = ($urandom_range(0, 9) != 0) ? 8'd0 : 8'($urandom);
            if ($urandom_range(0, 99) < 85) begin
                k = $urandom_range(0, 8 + 2 * NMAPS - 1);
                off = (k < 8) ? 4 * k : 32 + 4 * (k - 8);
            end else begin
                off = $urandom_range(0, 255);
            end
            wd = $urandom;
            if (off == 0) wd[2] = 1'b0;
            dp_idle = ($urandom_range(0, 3) != 0);
            req(opc, sz, ln, {$urandom, 24'($urandom), 8'(off)}, wd, err, rdv);
            repeat ($urandom_range(0, 2)) tick();
        end
        dp_idle = 1'b1;
        repeat (2) tick();
        check_outputs();

`ifdef UMI_REMAP_CFG_LOCK_EN
        req(5'h03, 3'd2, 8'd0, 64'h00, 32'h6, err, rdv);
        chk("lock_set_err", err, 2'b00);
        req(5'h03, 3'd2, 8'd0, 64'h08, 32'h1000, err, rdv);
        chk("lock_wr_err", err, 2'b11);
        req(5'h01, 3'd2, 8'd0, 64'h08, 32'h0, err, rdv);
        chk("lock_readback", rdv, sh[8]);
        req(5'h01, 3'd2, 8'd0, 64'h04, 32'h0, err, rdv);
        chk("lock_status", rdv[2], 1'b1);
`endif

        // reset while a response is held
        drive(5'h01, 3'd2, 8'd0, 64'h20, 32'h0);
        tick();
        udev_req_valid = 1'b0;
        chk("mid_resp_valid", udev_resp_valid, 1'b1);
        nreset = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_resp_dropped", udev_resp_valid, 1'b0);
        chk("mid_rst_enable", remap_enable, 1'b0);
        chk("mid_rst_old", old_row_col_address, '0);
        @(negedge clk);
        nreset = 1'b1;
        tick();
        chk("mid_rst_ready", udev_req_ready, 1'b1);
        req(5'h01, 3'd2, 8'd0, 64'h04, 32'h0, err, rdv);
        chk("mid_rst_status", rdv, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
